comm_resp_rx: RTL and testbench



---
 rtl/comm_resp_rx_if.sv | 21 ++
 rtl/comm_resp_rx.sv | 155 +++++++++++++++
 tb/tb_comm_resp_rx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/comm_resp_rx_if.sv
// Response-link signals between the command master and the response receiver.
// The bench drives through master; the receiver attaches to slave.
interface comm_resp_rx_if;
  logic       RX;
  logic       cmd_cmplt;
  logic       clr_resp_rdy;
  logic [7:0] resp;
  logic       resp_rdy;
  logic       frm_err;
  logic       resp_timeout;

  modport master (
    output RX, cmd_cmplt, clr_resp_rdy,
    input  resp, resp_rdy, frm_err, resp_timeout
  );

  modport slave (
    input  RX, cmd_cmplt, clr_resp_rdy,
    output resp, resp_rdy, frm_err, resp_timeout
  );
endinterface

// File: rtl/comm_resp_rx.sv
// 8N1 receiver for the one-byte response to each command.
// Also runs a timeout that is armed by cmd_cmplt and disarmed by a start edge.
module comm_resp_rx #(
  parameter int unsigned BAUD_DIV    = 2604,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input logic           clk,
  input logic           rst_n,
  comm_resp_rx_if.slave bus
);
  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [BW-1:0] HalfLoad = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] FullLoad = BW'(BAUD_DIV - 1);
  // The counter that reaches TIMEOUT_CYC-1 on this edge sets the flag on the same edge.
  localparam logic [TW-1:0] ToLast = TW'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            good_q, good_d;
  logic            err_q, err_d;
  logic            rx_meta, rx_sync, rx_prev;
  logic            start_edge, tick;
  logic [7:0]      resp_q;
  logic            rdy_q, frm_err_q;
  logic [TW-1:0]   to_cnt_q;
  logic            armed_q, timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = rx_prev & ~rx_sync;
  assign tick       = (baud_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      good_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      good_q  <= good_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    good_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q != StIdle) baud_d = baud_q - 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = StStart;
          baud_d  = HalfLoad;
        end
      end
      StStart: begin
        if (tick) begin
          baud_d = FullLoad;
          if (!rx_sync) begin
            bit_d   = '0;
            state_d = StData;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (tick) begin
          baud_d  = FullLoad;
          shift_d = {rx_sync, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (tick) begin
          state_d = StIdle;
          good_d  = rx_sync;
          err_d   = ~rx_sync;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A set from a completed frame beats any clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_q    <= 8'h00;
      rdy_q     <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      frm_err_q <= err_q;
      if (good_q) begin
        resp_q <= shift_q;
        rdy_q  <= 1'b1;
      end else if (bus.clr_resp_rdy || start_edge) begin
        rdy_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      armed_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else if (bus.cmd_cmplt) begin
      to_cnt_q  <= '0;
      armed_q   <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      if (bus.clr_resp_rdy) timeout_q <= 1'b0;
      if (start_edge) begin
        armed_q <= 1'b0;
      end else if (armed_q) begin
        to_cnt_q <= to_cnt_q + 1'b1;
        if (to_cnt_q == ToLast) begin
          timeout_q <= 1'b1;
          armed_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.resp         = resp_q;
  assign bus.resp_rdy     = rdy_q;
  assign bus.frm_err      = frm_err_q;
  assign bus.resp_timeout = timeout_q;
endmodule

// File: tb/tb_comm_resp_rx.sv
// Directed bench for comm_resp_rx with BAUD_DIV=16, TIMEOUT_CYC=400.
module tb_comm_resp_rx;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  comm_resp_rx_if bus ();

  comm_resp_rx #(
    .BAUD_DIV   (16),
    .TIMEOUT_CYC(400)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    bus.clr_resp_rdy = 1'b1;
    cycle();
    bus.clr_resp_rdy = 1'b0;
  endtask

  // One 160-cycle 8N1 frame; k counts edges since RX fell.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int clr_k,
                            input int rst_k, output int rdy_at, output int err_cnt);
    logic prev_rdy;
    int   b;
    rdy_at   = -1;
    err_cnt  = 0;
    prev_rdy = bus.resp_rdy;
    for (int k = 0; k < 160; k++) begin
      b = k / 16;
      if (b == 0) bus.RX = 1'b0;
      else if (b == 9) bus.RX = stop;
      else bus.RX = data[b-1];
      if (k == clr_k) bus.clr_resp_rdy = 1'b1;
      else if (k == clr_k + 1) bus.clr_resp_rdy = 1'b0;
      if (k == rst_k) rst_n = 1'b0;
      else if (k == rst_k + 2) rst_n = 1'b1;
      cycle();
      if (bus.resp_rdy && !prev_rdy && rdy_at < 0) rdy_at = k + 1;
      prev_rdy = bus.resp_rdy;
      if (bus.frm_err) err_cnt++;
    end
    bus.RX = 1'b1;
  endtask

  int ra, ec, ra2, rise_at;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.RX = 1'b1;
    bus.cmd_cmplt = 1'b0;
    bus.clr_resp_rdy = 1'b0;
    repeat (3) cycle();
    check("rst_resp", 32'(bus.resp), 32'h00);
    check("rst_rdy", 32'(bus.resp_rdy), 32'd0);
    check("rst_frm_err", 32'(bus.frm_err), 32'd0);
    check("rst_timeout", 32'(bus.resp_timeout), 32'd0);
    rst_n = 1'b1;
    repeat (4) cycle();

    for (int v = 0; v < 256; v++) begin
      send_frame(8'(v), 1'b1, -1, -1, ra, ec);
      check("lb_resp", 32'(bus.resp), 32'(v));
      check("lb_rdy_at", ra, 32'd156);
      check("lb_frm_err", ec, 32'd0);
      pulse_clr();
    end

    send_frame(8'hA5, 1'b0, -1, -1, ra, ec);
    check("fe_pulses", ec, 32'd1);
    check("fe_no_rdy", ra, 32'hFFFF_FFFF);
    check("fe_resp_kept", 32'(bus.resp), 32'hFF);
    check("fe_rdy", 32'(bus.resp_rdy), 32'd0);
    repeat (20) cycle();
    send_frame(8'h3C, 1'b1, -1, -1, ra, ec);
    check("fe_next_resp", 32'(bus.resp), 32'h3C);
    check("fe_next_rdy_at", ra, 32'd156);
    check("fe_next_err", ec, 32'd0);
    pulse_clr();

    ec = 0;
    ra = 0;
    bus.RX = 1'b0;
    repeat (4) cycle();
    bus.RX = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (bus.frm_err) ec++;
      if (bus.resp_rdy) ra++;
    end
    check("gl_err", ec, 32'd0);
    check("gl_rdy", ra, 32'd0);
    check("gl_resp", 32'(bus.resp), 32'h3C);
    check("gl_timeout", 32'(bus.resp_timeout), 32'd0);

    bus.cmd_cmplt = 1'b1;
    cycle();
    bus.cmd_cmplt = 1'b0;
    rise_at = -1;
    for (int k = 2; k <= 420; k++) begin
      cycle();
      if (bus.resp_timeout && rise_at < 0) rise_at = k;
    end
    check("to_rise_at", rise_at, 32'd400);
    check("to_sticky", 32'(bus.resp_timeout), 32'd1);
    bus.cmd_cmplt = 1'b1;
    cycle();
    bus.cmd_cmplt = 1'b0;
    check("to_cleared", 32'(bus.resp_timeout), 32'd0);
    repeat (199) cycle();
    send_frame(8'h77, 1'b1, -1, -1, ra, ec);
    repeat (100) cycle();
    check("to_disarmed", 32'(bus.resp_timeout), 32'd0);
    check("to_resp", 32'(bus.resp), 32'h77);
    check("to_rdy_at", ra, 32'd156);
    pulse_clr();

    send_frame(8'h11, 1'b1, -1, -1, ra, ec);
    send_frame(8'h22, 1'b1, 155, -1, ra2, ec);
    check("b2b_rdy1", ra, 32'd156);
    check("b2b_rdy2", ra2, 32'd156);
    check("ovr_resp", 32'(bus.resp), 32'h22);
    check("ovr_set_wins", 32'(bus.resp_rdy), 32'd1);
    pulse_clr();
    check("clr_rdy", 32'(bus.resp_rdy), 32'd0);

    send_frame(8'hF0, 1'b1, -1, 70, ra, ec);
    check("mr_resp", 32'(bus.resp), 32'h00);
    check("mr_rdy", 32'(bus.resp_rdy), 32'd0);
    check("mr_no_rdy", ra, 32'hFFFF_FFFF);
    check("mr_err", ec, 32'd0);
    check("mr_timeout", 32'(bus.resp_timeout), 32'd0);
    repeat (5) cycle();
    send_frame(8'h5A, 1'b1, -1, -1, ra, ec);
    check("mr_next_resp", 32'(bus.resp), 32'h5A);
    check("mr_next_rdy_at", ra, 32'd156);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
